// File: rtl/subtractor_4bits_pipeline_sel.sv
// subtractor_4bits_pipeline_sel
// Purpose: 4-bit unsigned subtractor, {bout, diff} = {1'b0,a} - {1'b0,b}. Valid/ready
// handshakes on both sides. The build-time selection on {HIGH_CLK, HIGH_CHIP} picks either
// a single output register (2'b01) or a two-stage split at bit 1 (all other values).
// Ports:
//   clk_i         rising-edge clock
//   rst_ni        asynchronous active-low reset
//   a_i, b_i      minuend / subtrahend
//   in_valid_i    a_i/b_i valid
//   in_ready_o    block can accept this cycle (combinational, depends on out_ready_i)
//   diff_o        (a - b) mod 16, registered
//   bout_o        borrow out (a < b), registered
//   out_valid_o   diff_o/bout_o valid, registered
//   out_ready_i   downstream accepts the result

`ifndef HIGH_SPEED
`define HIGH_SPEED 150
`endif

module subtractor_4bits_pipeline_sel #(
  parameter logic [8:0] CLK_FRENQUENCY = 9'd100,
  parameter logic       HIGH_CHIP      = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic [3:0] diff_o,
  output logic       bout_o,
  output logic       out_valid_o,
  input  logic       out_ready_i
);

  localparam int unsigned W  = 4;
  localparam int unsigned HW = W / 2;

  localparam logic       HIGH_CLK = (CLK_FRENQUENCY > 9'(`HIGH_SPEED));
  localparam logic [1:0] MODE_SEL = {HIGH_CLK, HIGH_CHIP};

  generate
    case (MODE_SEL)
      2'b01: begin : g_single
        logic [W-1:0] nb_c;
        logic [W:0]   sum_c;
        logic         in_fire_c;
        logic         out_fire_c;

        logic [W-1:0] diff_q, diff_d;
        logic         bout_q, bout_d;
        logic         valid_q, valid_d;

        // a - b as a + ~b + 1; the carry out is the inverted borrow
        assign nb_c  = ~b_i;
        assign sum_c = (W+1)'(a_i) + (W+1)'(nb_c) + (W+1)'(1);

        assign in_ready_o = !valid_q || out_ready_i;
        assign in_fire_c  = in_valid_i && in_ready_o;
        assign out_fire_c = valid_q && out_ready_i;

        // Next-state: load on input transfer, otherwise hold; valid drops on a bare drain
        always_comb begin
          diff_d  = diff_q;
          bout_d  = bout_q;
          valid_d = valid_q;
          if (in_fire_c) begin
            diff_d  = sum_c[W-1:0];
            bout_d  = ~sum_c[W];
            valid_d = 1'b1;
          end else if (out_fire_c) begin
            valid_d = 1'b0;
          end
        end

        // Output register
        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) begin
            diff_q  <= '0;
            bout_q  <= 1'b0;
            valid_q <= 1'b0;
          end else begin
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            valid_q <= valid_d;
          end
        end

        assign diff_o      = diff_q;
        assign bout_o      = bout_q;
        assign out_valid_o = valid_q;
      end

      default: begin : g_pipe
        logic [HW-1:0] nb_lo_c;
        logic [HW:0]   lo_sum_c;
        logic [HW-1:0] nb_hi_c;
        logic          cin_hi_c;
        logic [HW:0]   hi_sum_c;
        logic          s2_load_c;
        logic          in_fire_c;
        logic          out_fire_c;

        logic          s1_valid_q, s1_valid_d;
        logic [HW-1:0] s1_dlo_q, s1_dlo_d;
        logic          s1_borrow_q, s1_borrow_d;
        logic [HW-1:0] s1_ahi_q, s1_ahi_d;
        logic [HW-1:0] s1_bhi_q, s1_bhi_d;

        logic          s2_valid_q, s2_valid_d;
        logic [W-1:0]  s2_diff_q, s2_diff_d;
        logic          s2_bout_q, s2_bout_d;

        // Stage 1: low half of a + ~b + 1, borrow out of bit 1
        assign nb_lo_c  = ~b_i[HW-1:0];
        assign lo_sum_c = (HW+1)'(a_i[HW-1:0]) + (HW+1)'(nb_lo_c) + (HW+1)'(1);

        // Stage 2: high half minus the stage-1 borrow (carry-in = ~borrow)
        assign nb_hi_c  = ~s1_bhi_q;
        assign cin_hi_c = ~s1_borrow_q;
        assign hi_sum_c = (HW+1)'(s1_ahi_q) + (HW+1)'(nb_hi_c) + (HW+1)'(cin_hi_c);

        assign s2_load_c  = s1_valid_q && (!s2_valid_q || out_ready_i);
        assign in_ready_o = !s1_valid_q || s2_load_c;
        assign in_fire_c  = in_valid_i && in_ready_o;
        assign out_fire_c = s2_valid_q && out_ready_i;

        // Next-state for both stages; each holds while it cannot advance
        always_comb begin
          s1_valid_d  = s1_valid_q;
          s1_dlo_d    = s1_dlo_q;
          s1_borrow_d = s1_borrow_q;
          s1_ahi_d    = s1_ahi_q;
          s1_bhi_d    = s1_bhi_q;
          s2_valid_d  = s2_valid_q;
          s2_diff_d   = s2_diff_q;
          s2_bout_d   = s2_bout_q;

          if (in_fire_c) begin
            s1_valid_d  = 1'b1;
            s1_dlo_d    = lo_sum_c[HW-1:0];
            s1_borrow_d = ~lo_sum_c[HW];
            s1_ahi_d    = a_i[W-1:HW];
            s1_bhi_d    = b_i[W-1:HW];
          end else if (s2_load_c) begin
            s1_valid_d  = 1'b0;
          end

          if (s2_load_c) begin
            s2_valid_d = 1'b1;
            s2_diff_d  = {hi_sum_c[HW-1:0], s1_dlo_q};
            s2_bout_d  = ~hi_sum_c[HW];
          end else if (out_fire_c) begin
            s2_valid_d = 1'b0;
          end
        end

        // Stage registers
        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) begin
            s1_valid_q  <= 1'b0;
            s1_dlo_q    <= '0;
            s1_borrow_q <= 1'b0;
            s1_ahi_q    <= '0;
            s1_bhi_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_diff_q   <= '0;
            s2_bout_q   <= 1'b0;
          end else begin
            s1_valid_q  <= s1_valid_d;
            s1_dlo_q    <= s1_dlo_d;
            s1_borrow_q <= s1_borrow_d;
            s1_ahi_q    <= s1_ahi_d;
            s1_bhi_q    <= s1_bhi_d;
            s2_valid_q  <= s2_valid_d;
            s2_diff_q   <= s2_diff_d;
            s2_bout_q   <= s2_bout_d;
          end
        end

        assign diff_o      = s2_diff_q;
        assign bout_o      = s2_bout_q;
        assign out_valid_o = s2_valid_q;
      end
    endcase
  endgenerate

endmodule
